// File: rtl/pixel_frame_writer.sv
// Packs 8-bit filtered pixels into 32-bit words and writes them, through a small
// FIFO, to a word-addressed memory port; one address sequence per frame.
module pixel_frame_writer #(
  parameter int IMG_W      = 510,
  parameter int IMG_H      = 510,
  parameter int ADDR_W     = 16,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_in_valid,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_wr_strb,
  output logic              frame_done,
  output logic              overflow,
  output logic              busy
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       pack_q, pack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, overflow_q;

  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [3:0]        fifo_strb [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PW:0]       count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

  logic        last_pix, push, pop, wr_en, drop, full, empty, last_done;
  logic [31:0] push_data;
  logic [3:0]  push_strb;

  assign last_pix  = pixel_in_valid && (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  assign push      = pixel_in_valid && ((lane_q == 2'd3) || last_pix);
  assign full      = (count_q == (PW+1)'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = !empty && mem_wr_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign last_done = pop && fifo_last[rd_ptr_q];

  // Lanes above the current one are forced to zero so a partial word carries no stale bytes.
  always_comb begin
    push_data = '0;
    push_strb = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < lane_q) push_data[8*k +: 8] = pack_q[8*k +: 8];
    end
    case (lane_q)
      2'd0: begin push_data[7:0]   = pixel_in; push_strb = 4'b0001; end
      2'd1: begin push_data[15:8]  = pixel_in; push_strb = 4'b0011; end
      2'd2: begin push_data[23:16] = pixel_in; push_strb = 4'b0111; end
      default: begin push_data[31:24] = pixel_in; push_strb = 4'b1111; end
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    lane_d = lane_q;
    pack_d = pack_q;
    addr_d = addr_q;
    if (pixel_in_valid) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      lane_d = push ? 2'd0 : lane_q + 2'd1;
      case (lane_q)
        2'd0:    pack_d[7:0]   = pixel_in;
        2'd1:    pack_d[15:8]  = pixel_in;
        2'd2:    pack_d[23:16] = pixel_in;
        default: pack_d        = pack_q;
      endcase
    end
    // Address advances even on a dropped word, and restarts after a frame's last word.
    if (push) addr_d = last_pix ? BASE : addr_q + 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A frame whose last word is dropped never gets a handshake, so skip DRAIN for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pixel_in_valid) begin
          if (last_pix) state_d = wr_en ? DRAIN : IDLE;
          else          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (last_pix) state_d = wr_en ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (last_done) state_d = pixel_in_valid ? COLLECT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      lane_q       <= 2'd0;
      pack_q       <= '0;
      addr_q       <= BASE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      frame_done_q <= last_done;
      overflow_q   <= overflow_q | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data[wr_ptr_q] <= push_data;
      fifo_addr[wr_ptr_q] <= addr_q;
      fifo_strb[wr_ptr_q] <= push_strb;
      fifo_last[wr_ptr_q] <= last_pix;
    end
  end

  assign mem_wr_valid = !empty;
  assign mem_wr_data  = empty ? 32'h0 : fifo_data[rd_ptr_q];
  assign mem_wr_addr  = empty ? BASE  : fifo_addr[rd_ptr_q];
  assign mem_wr_strb  = empty ? 4'h0  : fifo_strb[rd_ptr_q];
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Scoreboard bench for pixel_frame_writer: a 6x3 instance checked word by word
// and a default-parameter instance used for the FIFO overflow case.
module tb_pixel_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        mem_wr_ready;
  logic        mem_wr_valid;
  logic [15:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        frame_done, overflow, busy;

  logic [7:0]  d_pixel;
  logic        d_valid, d_ready;
  logic        d_wr_valid;
  logic [15:0] d_wr_addr;
  logic [31:0] d_wr_data;
  logic [3:0]  d_wr_strb;
  logic        d_frame_done, d_overflow, d_busy;

  always #5 clk = ~clk;

  pixel_frame_writer #(.IMG_W(6), .IMG_H(3)) u_dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .frame_done(frame_done),
    .overflow(overflow), .busy(busy)
  );

  pixel_frame_writer u_dflt (
    .clk(clk), .rst(rst), .pixel_in(d_pixel), .pixel_in_valid(d_valid),
    .mem_wr_valid(d_wr_valid), .mem_wr_ready(d_ready), .mem_wr_addr(d_wr_addr),
    .mem_wr_data(d_wr_data), .mem_wr_strb(d_wr_strb), .frame_done(d_frame_done),
    .overflow(d_overflow), .busy(d_busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [15:0] a;
    logic [3:0]  s;
    bit          last;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   fd_count = 0;

  // Hand-packed words of the 6x3 frame carrying pixels 0x01..0x12.
  logic [31:0] frame_words [5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                                   32'h100F0E0D, 32'h00001211};
  logic [3:0]  frame_strbs [5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame_exp();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.d = frame_words[i];
      e.a = 16'(i);
      e.s = frame_strbs[i];
      e.last = (i == 4);
      sbq.push_back(e);
    end
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pixel_in = 8'(i + 1);
      pixel_in_valid = 1'b1;
    end
  endtask

  task automatic stop_pixels();
    @(posedge clk); #1;
    pixel_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while ((sbq.size() != 0 || mem_wr_valid) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc >= 200) begin
      n_err++;
      $display("FAIL %s_timeout: %0d words still expected, required 0", name, sbq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: checks handshakes against the queue, stall stability and frame_done timing.
  logic        hold_v;
  logic [31:0] hold_d;
  logic [15:0] hold_a;
  logic [3:0]  hold_s;
  bit          fd_exp;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
      fd_exp = 1'b0;
    end else begin
      if (fd_exp) begin
        chk("frame_done_pulse", {31'h0, frame_done}, 32'h1);
        fd_exp = 1'b0;
      end else if (frame_done) begin
        n_cmp++; n_err++;
        $display("FAIL frame_done_unexpected: got 1 required 0 at %0t", $time);
      end
      if (frame_done) fd_count++;
      if (hold_v) begin
        chk("stall_valid", {31'h0, mem_wr_valid}, 32'h1);
        chk("stall_data", mem_wr_data, hold_d);
        chk("stall_addr", {16'h0, mem_wr_addr}, {16'h0, hold_a});
        chk("stall_strb", {28'h0, mem_wr_strb}, {28'h0, hold_s});
      end
      hold_v = mem_wr_valid && !mem_wr_ready;
      hold_d = mem_wr_data;
      hold_a = mem_wr_addr;
      hold_s = mem_wr_strb;
      if (mem_wr_valid && mem_wr_ready) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_word: got %h@%h required none", mem_wr_data, mem_wr_addr);
        end else begin
          e = sbq.pop_front();
          chk("word_data", mem_wr_data, e.d);
          chk("word_addr", {16'h0, mem_wr_addr}, {16'h0, e.a});
          chk("word_strb", {28'h0, mem_wr_strb}, {28'h0, e.s});
          if (e.last) fd_exp = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'h0, mem_wr_valid}, 32'h0);
    chk({tag, "_data"}, mem_wr_data, 32'h0);
    chk({tag, "_addr"}, {16'h0, mem_wr_addr}, 32'h0);
    chk({tag, "_strb"}, {28'h0, mem_wr_strb}, 32'h0);
    chk({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
    chk({tag, "_overflow"}, {31'h0, overflow}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    pixel_in = '0; pixel_in_valid = 1'b0; mem_wr_ready = 1'b1;
    d_pixel = '0; d_valid = 1'b0; d_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_dflt_valid", {31'h0, d_wr_valid}, 32'h0);
    chk("reset_dflt_overflow", {31'h0, d_overflow}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single frame, ready always high.
    push_frame_exp();
    send_pixels(18);
    chk("busy_in_drain", {31'h0, busy}, 32'h1);
    stop_pixels();
    wait_drain("frame1");
    chk("frame1_done_count", fd_count, 1);
    chk("frame1_busy_idle", {31'h0, busy}, 32'h0);

    // Same frame with ready held low for 10 cycles once word 0 appears.
    mem_wr_ready = 1'b0;
    push_frame_exp();
    fork
      begin send_pixels(18); stop_pixels(); end
      begin
        cyc = 0;
        while (!mem_wr_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("stall_word0_seen", {31'h0, mem_wr_valid}, 32'h1);
        repeat (10) @(posedge clk);
        #1 mem_wr_ready = 1'b1;
      end
    join
    wait_drain("stall");
    chk("stall_overflow", {31'h0, overflow}, 32'h0);
    chk("stall_done_count", fd_count, 2);

    // Two back-to-back frames.
    push_frame_exp();
    push_frame_exp();
    send_pixels(18);
    send_pixels(18);
    stop_pixels();
    wait_drain("b2b");
    chk("b2b_done_count", fd_count, 4);

    // Reset mid-frame after 7 pixels, then a clean frame.
    mem_wr_ready = 1'b0;
    send_pixels(7);
    stop_pixels();
    chk("pre_reset_valid", {31'h0, mem_wr_valid}, 32'h1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_wr_ready = 1'b1;
    push_frame_exp();
    send_pixels(18);
    stop_pixels();
    wait_drain("post_reset");
    chk("post_reset_done_count", fd_count, 5);

    // Default instance, ready low: four words fill the FIFO, the fifth is dropped.
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      d_pixel = 8'(i + 1); d_valid = 1'b1;
    end
    @(posedge clk); #1;
    chk("dflt_16_overflow", {31'h0, d_overflow}, 32'h0);
    chk("dflt_16_valid", {31'h0, d_wr_valid}, 32'h1);
    for (int i = 16; i < 20; i++) begin
      d_pixel = 8'(i + 1); d_valid = 1'b1;
      @(posedge clk); #1;
    end
    d_valid = 1'b0;
    chk("dflt_20_overflow", {31'h0, d_overflow}, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    chk("dflt_overflow_sticky", {31'h0, d_overflow}, 32'h1);
    chk("dflt_head_data", d_wr_data, 32'h04030201);
    chk("dflt_head_addr", {16'h0, d_wr_addr}, 32'h0);
    chk("dflt_head_strb", {28'h0, d_wr_strb}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_frame_writer.md
PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 The module SHALL have parameter IMG_W, default 510, meaning filtered-frame width in pixels (512-pixel input minus 3x3 window border).
REQ-002 The module SHALL have parameter IMG_H, default 510, meaning filtered-frame height in pixels.
REQ-003 The module SHALL have parameter ADDR_W, default 16, meaning word-address width of the memory write port.
REQ-004 The module SHALL have parameter BASE_ADDR, default 0, meaning word address of the first word of every frame.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 4, meaning number of 32-bit words buffered (power of 2, at least 2).
REQ-006 The module SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 pixel_in  input  8  filtered pixel from the gaussian stage.
REQ-010 pixel_in_valid  input  1  pixel_in is valid this cycle; there is no back-pressure to upstream.
REQ-011 mem_wr_valid  output  1  a word is offered on the memory port.
REQ-012 mem_wr_ready  input  1  memory accepts the offered word.
REQ-013 mem_wr_addr  output  ADDR_W  word address of the offered word.
REQ-014 mem_wr_data  output  32  four packed pixels, earliest pixel in bits [7:0].
REQ-015 mem_wr_strb  output  4  byte enables; bit k covers bits [8k+7:8k].
REQ-016 frame_done  output  1  one-cycle pulse when the last word of a frame is accepted.
REQ-017 overflow  output  1  sticky: a packed word was dropped because the FIFO was full.
REQ-018 busy  output  1  high from the first accepted pixel of a frame until frame_done.

Function
REQ-019 Each cycle with pixel_in_valid=1, the block SHALL sample pixel_in into byte lane (pixel index mod 4) of the packing register.
REQ-020 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 SHALL advance per accepted pixel; col wraps to 0 with row+1; at (IMG_H-1, IMG_W-1) both wrap to 0.
REQ-021 On the edge that samples lane 3, the full word SHALL be pushed to the FIFO with strb 4'b1111.
REQ-022 On the edge that samples the last pixel of a frame, the packing register SHALL be pushed even if partial, unused lanes zero and strb covering only filled lanes (e.g. 2 lanes -> 4'b0011), and the lane index SHALL restart at 0.
REQ-023 FSM states IDLE, COLLECT, DRAIN: IDLE->COLLECT on first accepted pixel; COLLECT->DRAIN on the last pixel of the frame; DRAIN->IDLE (or COLLECT if a new pixel is accepted that cycle) when the last frame word completes its handshake.
REQ-024 Pixels accepted in DRAIN SHALL belong to the next frame and be packed normally; they SHALL NOT corrupt the draining frame's words or addresses.
REQ-025 mem_wr_valid SHALL equal FIFO non-empty; mem_wr_data/addr/strb SHALL come from the FIFO head; a word pushed on edge N SHALL be visible from cycle N+1.
REQ-026 While mem_wr_valid=1 and mem_wr_ready=0, data, addr and strb SHALL hold stable.
REQ-027 A handshake (valid and ready) SHALL pop the FIFO; simultaneous push and pop on a full FIFO SHALL succeed without drop.
REQ-028 Word addresses SHALL be BASE_ADDR, BASE_ADDR+1, ... per frame, assigned at push, modulo 2^ADDR_W, and restart at BASE_ADDR for each frame.
REQ-029 A push to a full FIFO without a simultaneous pop SHALL drop the word, set overflow, and still advance the address counter.
REQ-030 frame_done SHALL pulse for one cycle, on the cycle after the handshake of the frame's last word.

Reset
REQ-031 While rst=1: mem_wr_valid=0, mem_wr_data=0, mem_wr_addr=BASE_ADDR, mem_wr_strb=0, frame_done=0, overflow=0, busy=0, FIFO empty, counters and lane index 0, state IDLE.
REQ-032 Reset mid-frame SHALL discard buffered and partially packed pixels; the first pixel after reset SHALL be treated as (row 0, col 0).

Verification
REQ-033 IMG_W=6, IMG_H=3, ready=1, pixels 0x01..0x12 -> words 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3, 0x00001211@4 strb 0011; frame_done one cycle after word 4's handshake.
REQ-034 Same frame, ready=0 for 10 cycles after first word -> word 0 held stable; remaining words in order; overflow=0.
REQ-035 Default params, ready=0 throughout, 20 continuous pixels -> FIFO fills after 16 pixels, 5th word dropped, overflow=1 and stays 1.
REQ-036 IMG_W=6, IMG_H=3, two back-to-back frames, ready=1 -> second frame addresses restart at 0, two frame_done pulses, no lost words.
REQ-037 rst asserted after 7 pixels -> all outputs at reset values; next 18-pixel frame produces words exactly as in REQ-033.
